// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the LFSR job arbiter.
//   - state_t        : arbiter FSM encoding (2 bits)
//   - DWIDTH_DEFAULT : default LFSR / tap / count / result width
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int DWIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/lfsr_rr_pick.sv
// -----------------------------------------------------------------------------
// lfsr_rr_pick
//   Combinational round-robin picker: selects the first asserted bit of
//   'valid' at or after index 'ptr', wrapping modulo N_REQ.
// Ports
//   valid  in   N_REQ  request vector
//   ptr    in   IW     index with highest priority (always < N_REQ)
//   grant  out  N_REQ  one-hot grant (all zero when nothing is valid)
//   idx    out  IW     encoded grant index (0 when nothing is valid)
//   any    out  1      at least one request is valid
// -----------------------------------------------------------------------------
module lfsr_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // cand[k] is the requester that sits k places after ptr in priority order.
    logic [IW-1:0] cand [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IW:0] sum;
            assign sum       = {1'b0, ptr} + (IW+1)'(gi);
            assign cand[gi]  = (sum >= (IW+1)'(N_REQ)) ? IW'(sum - (IW+1)'(N_REQ))
                                                       : sum[IW-1:0];
        end
    endgenerate

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk from lowest to highest priority so the highest-priority hit is
        // the one that survives.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_job_arbiter.sv
// -----------------------------------------------------------------------------
// lfsr_job_arbiter
//   Shares one LFSR core between N_REQ requesters. Jobs (tap mask + step
//   count) are accepted round-robin, launched on the core, supervised with a
//   timeout and returned as a tagged response.
// Ports
//   wb_clk_i / wb_rst_i     clock, asynchronous active-high reset
//   req_valid/taps/count    per-requester job, packed i*DWIDTH +: DWIDTH
//   req_ready               one-hot accept strobe (IDLE only)
//   core_start/taps/count   launch pulse and latched job to the core
//   core_abort              one-cycle pulse when the job times out
//   core_done/core_num      completion pulse and result from the core
//   rsp_valid/id/num/err    response, held until rsp_ready
//   rsp_ready               consumer accepts the response
// -----------------------------------------------------------------------------
module lfsr_job_arbiter
    import lfsr_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DWIDTH  = DWIDTH_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DWIDTH-1:0]    req_taps,
    input  logic [N_REQ*DWIDTH-1:0]    req_count,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       core_start,
    output logic [DWIDTH-1:0]          core_taps,
    output logic [DWIDTH-1:0]          core_count,
    output logic                       core_abort,
    input  logic                       core_done,
    input  logic [DWIDTH-1:0]          core_num,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [DWIDTH-1:0]          rsp_num,
    output logic                       rsp_err,
    input  logic                       rsp_ready
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [IW-1:0]      rr_ptr_reg;
    logic [IW-1:0]      id_reg;
    logic [DWIDTH-1:0]  taps_reg;
    logic [DWIDTH-1:0]  count_reg;
    logic [CW-1:0]      cnt_reg;
    logic [DWIDTH-1:0]  rsp_num_reg;
    logic               rsp_err_reg;

    // Unpacked views of the per-requester job fields.
    logic [DWIDTH-1:0]  taps_arr  [N_REQ];
    logic [DWIDTH-1:0]  count_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign taps_arr[gi]  = req_taps[gi*DWIDTH +: DWIDTH];
            assign count_arr[gi] = req_count[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    logic [N_REQ-1:0]   pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    lfsr_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    logic [DWIDTH-1:0]  pick_taps;
    logic [DWIDTH-1:0]  pick_count;
    logic               zero_taps;
    logic               timeout_hit;
    logic [IW-1:0]      ptr_after_id;

    assign pick_taps    = taps_arr[pick_idx];
    assign pick_count   = count_arr[pick_idx];
    assign zero_taps    = (pick_taps == '0);
    assign timeout_hit  = (cnt_reg == CNT_LAST);
    assign ptr_after_id = (id_reg == IW'(N_REQ - 1)) ? '0 : id_reg + IW'(1);

    // Next-state and strobe outputs.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        core_start = 1'b0;
        core_abort = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Gated by reset so no accept strobe is seen while the
                // registers are being held in reset.
                if (pick_any && !wb_rst_i) begin
                    req_ready  = pick_grant;
                    state_next = zero_taps ? ST_RESPOND : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                core_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the timeout cycle takes precedence.
                if (core_done) begin
                    state_next = ST_RESPOND;
                end else if (timeout_hit) begin
                    core_abort = 1'b1;
                    state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, job latches, timeout counter and response registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= '0;
            id_reg      <= '0;
            taps_reg    <= '0;
            count_reg   <= '0;
            cnt_reg     <= '0;
            rsp_num_reg <= '0;
            rsp_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        id_reg      <= pick_idx;
                        taps_reg    <= pick_taps;
                        count_reg   <= pick_count;
                        rsp_num_reg <= '0;
                        rsp_err_reg <= zero_taps;
                    end
                end
                ST_LAUNCH: begin
                    cnt_reg <= '0;
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (core_done) begin
                        rsp_num_reg <= core_num;
                        rsp_err_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_num_reg <= '0;
                        rsp_err_reg <= 1'b1;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        rr_ptr_reg <= ptr_after_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_taps  = taps_reg;
    assign core_count = count_reg;
    assign rsp_id     = id_reg;
    assign rsp_num    = rsp_num_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_lfsr_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lfsr_job_arbiter
//   Directed stimulus with a scoreboard: expected grants, core launches and
//   responses are queued when a job is issued; a negedge monitor pops and
//   compares them whenever the DUT presents the matching event.
// -----------------------------------------------------------------------------
module tb_lfsr_job_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_taps;
    logic [N*DW-1:0] req_count;
    logic [N-1:0]    req_ready;
    logic            core_start;
    logic [DW-1:0]   core_taps;
    logic [DW-1:0]   core_count;
    logic            core_abort;
    logic            core_done;
    logic [DW-1:0]   core_num;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_num;
    logic            rsp_err;
    logic            rsp_ready;

    lfsr_job_arbiter #(
        .N_REQ   (N),
        .DWIDTH  (DW),
        .TIMEOUT (TO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_valid  (req_valid),
        .req_taps   (req_taps),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .core_start (core_start),
        .core_taps  (core_taps),
        .core_count (core_count),
        .core_abort (core_abort),
        .core_done  (core_done),
        .core_num   (core_num),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_num    (rsp_num),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready)
    );

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] num;
        logic          err;
    } rsp_t;

    rsp_t        exp_rsp[$];
    logic [15:0] exp_start[$];
    int          exp_grant[$];
    int          grant_cyc[$];
    int          start_cyc[$];
    int          rise_cyc[$];
    int          hs_cyc[$];
    int          abort_cyc[$];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          core_delay = 3;
    logic [DW-1:0] core_result = '0;

    initial forever #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 10000", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got an event expected none (cycle %0d)", name, cyc);
    endtask

    // Core model: completes core_delay cycles after the launch pulse
    // (core_delay == 0 means it never completes).
    initial begin : core_model
        bit busy;
        int st;
        busy = 1'b0;
        st = 0;
        core_done = 1'b0;
        core_num = '0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i || core_abort) begin
                busy = 1'b0;
            end else if (core_start) begin
                busy = (core_delay > 0);
                st = cyc;
            end
            @(posedge wb_clk_i);
            #1;
            core_done = 1'b0;
            core_num = '0;
            if (busy && cyc == st + core_delay) begin
                core_done = 1'b1;
                core_num = core_result;
                busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard checker.
    initial begin : monitor
        logic pv;
        logic phs;
        logic hs;
        rsp_t pf;
        rsp_t cur;
        rsp_t e;
        logic [15:0] es;
        int g;
        pv = 1'b0;
        phs = 1'b0;
        pf = '0;
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_i) begin
                pv = 1'b0;
                phs = 1'b0;
                continue;
            end
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                check("grant_onehot", 32'($countones(req_ready)), 32'd1);
                check("grant_valid", 32'(req_ready & ~req_valid), 32'd0);
                grant_cyc.push_back(cyc);
                $display("cycle %0d: grant req%0d", cyc, g);
                if (exp_grant.size() == 0) unexpected("grant_unexp");
                else check("grant_idx", 32'(g), 32'(exp_grant.pop_front()));
            end
            if (core_start) begin
                start_cyc.push_back(cyc);
                $display("cycle %0d: core_start taps=%02h count=%02h", cyc, core_taps, core_count);
                if (exp_start.size() == 0) unexpected("start_unexp");
                else begin
                    es = exp_start.pop_front();
                    check("start_taps", 32'(core_taps), 32'(es[15:8]));
                    check("start_count", 32'(core_count), 32'(es[7:0]));
                end
            end
            if (core_abort) begin
                abort_cyc.push_back(cyc);
                $display("cycle %0d: core_abort", cyc);
            end
            cur = '{id: rsp_id, num: rsp_num, err: rsp_err};
            hs = rsp_valid && rsp_ready;
            if (rsp_valid && !pv) rise_cyc.push_back(cyc);
            if (rsp_valid && pv && !phs) check("rsp_stable", 32'(cur), 32'(pf));
            if (rsp_valid && req_valid != '0) check("rdy_busy", 32'(req_ready), 32'd0);
            if (hs) begin
                hs_cyc.push_back(cyc);
                $display("cycle %0d: rsp id=%0d num=%02h err=%0d", cyc, rsp_id, rsp_num, rsp_err);
                if (exp_rsp.size() == 0) unexpected("rsp_unexp");
                else begin
                    e = exp_rsp.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_num", 32'(rsp_num), 32'(e.num));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            pv = rsp_valid;
            phs = hs;
            pf = cur;
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    function automatic int cnt_of(input int sel);
        case (sel)
            0: return grant_cyc.size();
            1: return start_cyc.size();
            2: return rise_cyc.size();
            3: return hs_cyc.size();
            default: return abort_cyc.size();
        endcase
    endfunction

    task automatic wait_for(input int sel, input int target, input string name);
        int k;
        k = 0;
        while (cnt_of(sel) < target && k < 400) begin
            tick();
            k++;
        end
        if (cnt_of(sel) < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timed out with %0d events, expected %0d", name, cnt_of(sel), target);
        end
    endtask

    task automatic issue(input int idx, input logic [DW-1:0] t, input logic [DW-1:0] c);
        req_taps[idx*DW +: DW] = t;
        req_count[idx*DW +: DW] = c;
        req_valid[idx] = 1'b1;
        exp_grant.push_back(idx);
        if (t != '0) exp_start.push_back({t, c});
    endtask

    task automatic expect_rsp(input int id, input logic [DW-1:0] num, input logic err);
        exp_rsp.push_back('{id: 2'(id), num: num, err: err});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_core_start"}, 32'(core_start), 32'd0);
        check({tag, "_core_abort"}, 32'(core_abort), 32'd0);
        check({tag, "_core_taps"}, 32'(core_taps), 32'd0);
        check({tag, "_core_count"}, 32'(core_count), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_num"}, 32'(rsp_num), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin : main
        int g0, s0, r0, h0, a0;
        req_valid = '0;
        req_taps = '0;
        req_count = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset state, with all requesters pending.
        req_valid = 4'b1111;
        #1;
        check_outputs_zero("reset");

        // Test 2: round-robin order 0,1,2,3,0 with everyone held valid.
        core_delay = 3;
        core_result = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            exp_grant.push_back(i % 4);
            exp_start.push_back({8'(8'h10 + (i % 4)), 8'((i % 4) + 1)});
            expect_rsp(i % 4, 8'h3C, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            req_taps[i*DW +: DW] = 8'(8'h10 + i);
            req_count[i*DW +: DW] = 8'(i + 1);
        end
        tick();
        wb_rst_i = 1'b0;
        wait_for(0, 5, "t2_grants");
        req_valid = '0;
        wait_for(3, 5, "t2_rsps");
        check("t2_starts", 32'(start_cyc.size()), 32'd5);

        // Test 1: single job, done 7 cycles after launch.
        g0 = grant_cyc.size(); s0 = start_cyc.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
        core_delay = 7;
        core_result = 8'h2B;
        issue(0, 8'h90, 8'h05);
        expect_rsp(0, 8'h2B, 1'b0);
        wait_for(0, g0 + 1, "t1_grant");
        req_valid[0] = 1'b0;
        wait_for(3, h0 + 1, "t1_rsp");
        if (grant_cyc.size() > g0 && start_cyc.size() > s0 && rise_cyc.size() > r0) begin
            check("t1_start_lat", 32'(start_cyc[s0]), 32'(grant_cyc[g0] + 1));
            check("t1_rsp_lat", 32'(rise_cyc[r0]), 32'(grant_cyc[g0] + 9));
        end

        // Test 3: zero tap mask answers immediately with an error.
        g0 = grant_cyc.size(); s0 = start_cyc.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
        issue(2, 8'h00, 8'h07);
        expect_rsp(2, 8'h00, 1'b1);
        wait_for(0, g0 + 1, "t3_grant");
        req_valid[2] = 1'b0;
        wait_for(3, h0 + 1, "t3_rsp");
        check("t3_no_start", 32'(start_cyc.size()), 32'(s0));
        if (grant_cyc.size() > g0 && rise_cyc.size() > r0)
            check("t3_rsp_lat", 32'(rise_cyc[r0]), 32'(grant_cyc[g0] + 1));

        // Test 4: core never completes; abort after TO cycles, next job follows.
        g0 = grant_cyc.size(); s0 = start_cyc.size(); r0 = rise_cyc.size();
        h0 = hs_cyc.size(); a0 = abort_cyc.size();
        core_delay = 0;
        issue(3, 8'hA5, 8'h10);
        expect_rsp(3, 8'h00, 1'b1);
        wait_for(0, g0 + 1, "t4_grant");
        req_valid[3] = 1'b0;
        wait_for(1, s0 + 1, "t4_start");
        core_delay = 4;
        core_result = 8'h77;
        issue(1, 8'h21, 8'h03);
        expect_rsp(1, 8'h77, 1'b0);
        wait_for(0, g0 + 2, "t4_grant2");
        req_valid[1] = 1'b0;
        wait_for(3, h0 + 2, "t4_rsps");
        check("t4_abort_cnt", 32'(abort_cyc.size()), 32'(a0 + 1));
        if (abort_cyc.size() > a0 && start_cyc.size() > s0 && rise_cyc.size() > r0
            && hs_cyc.size() > h0 && grant_cyc.size() > g0 + 1) begin
            check("t4_abort_lat", 32'(abort_cyc[a0]), 32'(start_cyc[s0] + TO));
            check("t4_rsp_lat", 32'(rise_cyc[r0]), 32'(abort_cyc[a0] + 1));
            check("t4_next_grant", 32'(grant_cyc[g0 + 1]), 32'(hs_cyc[h0] + 1));
        end

        // Test 5: consumer stalls 10 cycles while req1 is pending.
        g0 = grant_cyc.size(); r0 = rise_cyc.size(); h0 = hs_cyc.size();
        rsp_ready = 1'b0;
        core_delay = 2;
        core_result = 8'hC3;
        issue(3, 8'h0F, 8'h02);
        expect_rsp(3, 8'hC3, 1'b0);
        wait_for(0, g0 + 1, "t5_grant");
        req_valid[3] = 1'b0;
        wait_for(2, r0 + 1, "t5_rise");
        core_result = 8'h44;
        issue(1, 8'h33, 8'h01);
        expect_rsp(1, 8'h44, 1'b0);
        repeat (10) tick();
        check("t5_no_hs", 32'(hs_cyc.size()), 32'(h0));
        check("t5_no_grant", 32'(grant_cyc.size()), 32'(g0 + 1));
        rsp_ready = 1'b1;
        wait_for(0, g0 + 2, "t5_grant2");
        req_valid[1] = 1'b0;
        if (grant_cyc.size() > g0 + 1 && hs_cyc.size() > h0)
            check("t5_accept_lat", 32'(grant_cyc[g0 + 1]), 32'(hs_cyc[h0] + 1));
        wait_for(3, h0 + 2, "t5_rsps");

        // Test 6: reset in the middle of WAIT drops the job; req0 wins afterwards.
        g0 = grant_cyc.size(); s0 = start_cyc.size(); h0 = hs_cyc.size(); a0 = abort_cyc.size();
        core_delay = 0;
        issue(2, 8'h55, 8'h09);
        wait_for(0, g0 + 1, "t6_grant");
        req_valid[2] = 1'b0;
        wait_for(1, s0 + 1, "t6_start");
        repeat (3) tick();
        #1;
        wb_rst_i = 1'b1;
        #1;
        check_outputs_zero("t6_async");
        tick();
        tick();
        wb_rst_i = 1'b0;
        check("t6_dropped", 32'(hs_cyc.size()), 32'(h0));
        issue(0, 8'h00, 8'h00);
        issue(2, 8'h00, 8'h00);
        expect_rsp(0, 8'h00, 1'b1);
        expect_rsp(2, 8'h00, 1'b1);
        wait_for(0, g0 + 2, "t6_grant0");
        req_valid[0] = 1'b0;
        wait_for(0, g0 + 3, "t6_grant2");
        req_valid[2] = 1'b0;
        wait_for(3, h0 + 2, "t6_rsps");
        check("t6_no_abort", 32'(abort_cyc.size()), 32'(a0));

        repeat (5) tick();
        check("end_exp_rsp", 32'(exp_rsp.size()), 32'd0);
        check("end_exp_start", 32'(exp_start.size()), 32'd0);
        check("end_exp_grant", 32'(exp_grant.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
